// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the FIFO status bundle used by the rx and tx FIFOs.
package uart_pkg;

    localparam int unsigned UART_DATA_WDTH = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic ovf;
    } uart_fifo_stat_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WDTH simple dual-port storage: synchronous write, asynchronous read.
// The asynchronous read port lets the FIFO head appear on the output with no extra cycle.
module uart_fifo_mem #(
    parameter int unsigned DATA_WDTH = 8,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                 CLKip,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_WDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DATA_WDTH-1:0] rdata
);

    logic [DATA_WDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLKip) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind uart_rx: one push per rising edge of RX_DONEi,
// first-word-fall-through valid/ready read side, sticky overflow when a byte hits a full FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WDTH = UART_DATA_WDTH,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned PW       = AW + 1
) (
    input  logic                 CLKip,
    input  logic                 rst,
    input  logic                 RX_DONEi,
    input  logic [DATA_WDTH-1:0] RX_DATAi,
    input  logic                 CLRi,
    input  logic                 OVF_CLRi,
    input  logic                 READYi,
    output logic                 VALIDo,
    output logic [DATA_WDTH-1:0] DATAo,
    output logic [PW-1:0]        COUNTo,
    output logic                 EMPTYo,
    output logic                 FULLo,
    output logic                 OVFo
);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            done_q;
    logic            ovf_q;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            rd_en;
    logic            ovf_set;
    uart_fifo_stat_t stat;

    // Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
    assign stat = '{
        empty: (wr_ptr == rd_ptr),
        full:  (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]),
        ovf:   ovf_q
    };

    assign push    = RX_DONEi & ~done_q;
    assign pop     = ~stat.empty & READYi;
    // A pop on a full FIFO frees the slot the incoming byte is written into.
    assign wr_en   = push & (~stat.full | pop) & ~CLRi;
    assign rd_en   = pop & ~CLRi;
    assign ovf_set = push & stat.full & ~pop & ~CLRi;

    always_ff @(posedge CLKip) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= RX_DONEi;
            if (CLRi) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            end
            // A new overflow outranks a clear request on the same edge.
            if (ovf_set)       ovf_q <= 1'b1;
            else if (OVF_CLRi) ovf_q <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DATA_WDTH (DATA_WDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .CLKip (CLKip),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (RX_DATAi),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (DATAo)
    );

    assign COUNTo = wr_ptr - rd_ptr;
    assign VALIDo = ~stat.empty;
    assign EMPTYo = stat.empty;
    assign FULLo  = stat.full;
    assign OVFo   = stat.ovf;

endmodule
